// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use/branch-flush/memory-wait pipeline control; HAZARD_PERF_CNT_EN adds perf counters
module hazard_flush_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        sys_clk,
    input  logic        sys_start,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_regdst_i,
    input  logic        ex_branch_taken_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ready_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        mem_stall_o,
    output logic        mem_err_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] memwait_cnt_o,
`endif
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2, MEM_WAIT = 2'd3} state_e;
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);
    state_e      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic        load_use, mem_wait;
    logic        pc_w, ifid_w, ifid_f, idex_f, stall;
    always_comb begin
        load_use = ex_memread_i && ex_regdst_i != 5'd0 &&
                   ((id_rs1_used_i && id_rs1_i == ex_regdst_i) || (id_rs2_used_i && id_rs2_i == ex_regdst_i));
        mem_wait = dmem_req_i && !dmem_ready_i;
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        wcnt_d   = wcnt_q;
        pc_w     = 1'b0;
        ifid_w   = 1'b0;
        ifid_f   = 1'b0;
        idex_f   = 1'b0;
        stall    = 1'b0;
        if (state_q == BOOT) begin
            ifid_f  = 1'b1;
            idex_f  = 1'b1;
            state_d = RUN;
        end else if (mem_wait && state_q != MEM_WAIT) begin
            stall   = 1'b1;
            wcnt_d  = 16'd1;
            state_d = MEM_WAIT;
        end else if (mem_wait) begin
            stall  = 1'b1;
            wcnt_d = (wcnt_q == TIMEOUT) ? wcnt_q : wcnt_q + 16'd1;
        end else if (state_q == FLUSH || (state_q == MEM_WAIT && fcnt_q != 4'd0)) begin
            // a flush interrupted by a memory wait resumes here with its remaining count
            {pc_w, ifid_w, ifid_f, idex_f} = 4'hf;
            fcnt_d  = (fcnt_q <= 4'd1) ? 4'd0 : fcnt_q - 4'd1;
            state_d = (fcnt_q <= 4'd1) ? RUN : FLUSH;
        end else if (ex_branch_taken_i) begin
            {pc_w, ifid_w, ifid_f, idex_f} = 4'hf;
            fcnt_d  = (FLUSH_CYCLES > 1) ? FLUSH_LOAD : 4'd0;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (load_use) begin
            idex_f  = 1'b1;
            state_d = RUN;
        end else begin
            pc_w    = 1'b1;
            ifid_w  = 1'b1;
            state_d = RUN;
        end
        err_d = err_q || (stall && wcnt_d == TIMEOUT);
    end
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            state_q <= BOOT;
            fcnt_q  <= 4'd0;
            wcnt_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end
    // outputs are held inactive while reset is asserted
    assign pc_write_o   = pc_w && sys_start;
    assign ifid_write_o = ifid_w && sys_start;
    assign ifid_flush_o = ifid_f && sys_start;
    assign idex_flush_o = idex_f && sys_start;
    assign mem_stall_o  = stall && sys_start;
    assign mem_err_o    = err_q;
    assign state_o      = state_q;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, memwait_cnt_q, memwait_cnt_d;
    always_comb begin
        stall_cnt_d   = stall_cnt_q + {31'd0, idex_f && !ifid_f};
        flush_cnt_d   = flush_cnt_q + {31'd0, ifid_f && state_q != BOOT};
        memwait_cnt_d = memwait_cnt_q + {31'd0, stall};
    end
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            stall_cnt_q   <= 32'd0;
            flush_cnt_q   <= 32'd0;
            memwait_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`endif
endmodule
